gpu_fb_sink: RTL and testbench
==============================

Name: gpu_fb_sink

Overview:
- Receiving end of the GPU framebuffer pixel interface (fb_x/fb_y/fb_color/fb_write).
- Converts pixel coordinates to linear word addresses and buffers them in a small FIFO.
- Drains the FIFO to a 16-bit memory write port that may be shared, so every write waits for a grant.
- Also executes a full-screen clear command. Back-pressure reaches the GPU through fb_full.

Parameters:
FB_WIDTH, 256, pixels per line; power of two.
FB_HEIGHT, 256, lines per frame.
BASE_ADDR, 0, word address of pixel (0,0).
FIFO_DEPTH, 8, pixel buffer entries; power of two, >= 2.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
fb_x  in  8  pixel column.
fb_y  in  8  pixel row.
fb_color  in  16  pixel colour.
fb_write  in  1  pixel valid, one pixel per cycle.
fb_full  out  1  sink cannot accept a pixel this cycle.
clear_start  in  1  one-cycle pulse: fill the frame with clear_color.
clear_color  in  16  fill colour, sampled on an accepted clear_start.
clear_busy  out  1  clear pending or in progress.
mem_addr  out  16  write word address.
mem_wdata  out  16  write data.
mem_write  out  1  write request.
mem_grant  in  1  request accepted this cycle; holding it at 1 gives a private port.
dropped_count  out  16  saturating count of rejected pixels.

Behaviour:
- Reset:
  - Affects clk and rst only: one clock, synchronous active-high reset.
  - FIFO empty, state IDLE.
  - fb_full=0, clear_busy=0, mem_write=0, mem_addr=0, mem_wdata=0, dropped_count=0.
  - rst asserted mid-clear or mid-drain discards all pending pixels and the clear. No further mem_write after the reset edge.
- Accept:
  - A pixel is pushed when fb_write=1, fb_full=0 and (fb_x<FB_WIDTH, fb_y<FB_HEIGHT).
  - Stored entry is {addr, color}, where addr = (BASE_ADDR + fb_y*FB_WIDTH + fb_x) mod 2^16. Wrap is silent.
  - Out-of-range pixels and fb_write while fb_full=1 are dropped. dropped_count += 1, saturating at 0xFFFF.
- fb_full:
  - Registered.
  - High when the next-cycle count == FIFO_DEPTH, or when state != IDLE.
  - A push and a pop in the same cycle leave the count unchanged.
  - A pop from a full FIFO deasserts fb_full in the following cycle.
- Drain:
  - In IDLE and CLEAR_WAIT, mem_write = FIFO non-empty.
  - mem_addr and mem_wdata are the FIFO head (registered storage, combinational read).
  - A pixel accepted at edge N is visible on the memory port in cycle N+1.
  - The head is popped on the edge where mem_write & mem_grant.
  - Without a grant, the request is held stable.
  - Write order equals acceptance order.
- State machine:
  - IDLE -> CLEAR_WAIT on clear_start. clear_color is latched, clear_busy goes 1 on the next edge and fb_full goes 1.
  - CLEAR_WAIT: the FIFO keeps draining. Move to CLEAR in the cycle after the FIFO is empty; pixels accepted before clear_start are written before the fill.
  - CLEAR:
    - Index counter i runs 0..FB_WIDTH*FB_HEIGHT-1.
    - mem_addr = BASE_ADDR+i (mod 2^16), mem_wdata = latched colour, mem_write=1.
    - i advances on each grant.
    - The grant at the last index returns to IDLE; clear_busy and fb_full drop on that edge.
- clear_start while state != IDLE is ignored with no effect.
- clear_start and a pixel in the same IDLE cycle: the pixel is accepted first (fb_full is still 0), then the clear starts.
- Full clear time with a permanent grant: (FIFO drain) + 1 + FB_WIDTH*FB_HEIGHT cycles.

Decomposition:
- Package gpu_fb_pkg:
  - FB_WIDTH / FB_HEIGHT defaults.
  - Pixel entry struct {addr[15:0], color[15:0]}.
  - State enum {IDLE, CLEAR_WAIT, CLEAR}.
  - Address-computation function.
- Sub-module gpu_fb_fifo: synchronous FIFO with parameters WIDTH=32 and DEPTH.
  - Ports push/pop/head/count/full/empty.
  - Combinational head read; push and pop in the same cycle allowed.
- The top level holds the state machine, address arithmetic, clear counter and drop counter.

Test Plan:
- Pixel write, mem_grant=1. Reset, then fb_x=3, fb_y=2, color=0xABCD, one cycle. Required: next cycle mem_write=1, mem_addr=0x0203, mem_wdata=0xABCD; after that, mem_write=0.
- Back-pressure, mem_grant=0. Push 8 pixels (x=0..7, y=0).
  - fb_full=1 after the 8th. A 9th write increments dropped_count to 1.
  - Raise mem_grant: memory receives addrs 0..7 in order; fb_full drops one cycle after the first pop.
- Bounds, FB_WIDTH=16, FB_HEIGHT=16. Write at x=16, y=0 and at x=0, y=20. Required: no mem_write, dropped_count=2.
- Clear with pending pixels, FB_WIDTH=FB_HEIGHT=4, BASE_ADDR=0x100. Queue 2 pixels, then clear_start with colour 0x1234.
  - The 2 pixel writes come first, then addrs 0x100..0x10F with 0x1234.
  - clear_busy high throughout and low after the 16th grant.
  - A clear_start issued mid-clear is ignored (exactly 16 fill writes).
- Grant stall and reset, mem_grant toggling 1010…
  - During the clear, mem_addr is held across non-grant cycles.
  - Assert rst at fill index 5: next cycle mem_write=0, clear_busy=0, fb_full=0, dropped_count=0.
  - A subsequent pixel writes normally.
- Address wrap, BASE_ADDR=0xFFFF, FB_WIDTH=256. Pixel x=1, y=0 produces mem_addr=0x0000.

Source files
------------

// File: rtl/gpu_fb_pkg.sv
// +--------------------------------------------------------------------+
// | gpu_fb_pkg : shared types and address helper for the fb sink       |
// | Revision   : 1.0                                                    |
// +--------------------------------------------------------------------+
`default_nettype none

package gpu_fb_pkg;

  localparam int unsigned FB_WIDTH_DEFAULT  = 256;
  localparam int unsigned FB_HEIGHT_DEFAULT = 256;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] color;
  } pix_entry_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_WAIT = 2'd1,
    CLEAR      = 2'd2
  } fb_state_t;

  // Linear word address of a pixel; overflow past 16 bits wraps silently.
  function automatic logic [15:0] pix_addr(input logic [15:0] base,
                                           input int unsigned width,
                                           input logic [7:0]  x,
                                           input logic [7:0]  y);
    logic [31:0] sum;
    sum = 32'(base) + 32'(y) * width + 32'(x);
    return sum[15:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpu_fb_fifo.sv
// +--------------------------------------------------------------------+
// | gpu_fb_fifo : synchronous FIFO, combinational head, push+pop ok    |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module gpu_fb_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/gpu_fb_sink.sv
// +--------------------------------------------------------------------+
// | gpu_fb_sink : GPU pixel port -> buffered, granted 16-bit mem writes |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
`default_nettype none

module gpu_fb_sink
  import gpu_fb_pkg::*;
#(
  parameter int unsigned FB_WIDTH   = FB_WIDTH_DEFAULT,
  parameter int unsigned FB_HEIGHT  = FB_HEIGHT_DEFAULT,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  fb_x,
  input  logic [7:0]  fb_y,
  input  logic [15:0] fb_color,
  input  logic        fb_write,
  output logic        fb_full,
  input  logic        clear_start,
  input  logic [15:0] clear_color,
  output logic        clear_busy,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_write,
  input  logic        mem_grant,
  output logic [15:0] dropped_count
);

  localparam int unsigned NPIX  = FB_WIDTH * FB_HEIGHT;
  localparam int          IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int          CW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NPIX - 1);

  fb_state_t        state;
  fb_state_t        state_next;
  logic [IDX_W-1:0] idx;
  logic [15:0]      clr_color;
  logic [15:0]      fill_addr;

  logic             in_range;
  logic             accept;
  logic             reject;
  logic             pop;
  pix_entry_t       push_entry;
  pix_entry_t       head_entry;
  logic [CW-1:0]    fifo_count;
  logic [CW-1:0]    count_next;
  logic             fifo_full;
  logic             fifo_empty;

  assign in_range   = (32'(fb_x) < FB_WIDTH) && (32'(fb_y) < FB_HEIGHT);
  assign accept     = fb_write && !fb_full && !fifo_full && in_range;
  assign reject     = fb_write && !accept;
  assign push_entry = '{addr:  pix_addr(16'(BASE_ADDR), FB_WIDTH, fb_x, fb_y),
                        color: fb_color};
  assign pop        = mem_write && mem_grant && (state != CLEAR);
  assign fill_addr  = 16'(32'(BASE_ADDR) + 32'(idx));
  assign clear_busy = (state != IDLE);

  gpu_fb_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (push_entry),
    .head  (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    count_next = fifo_count;
    if (accept && !pop)      count_next = fifo_count + CW'(1);
    else if (!accept && pop) count_next = fifo_count - CW'(1);
  end

  always_comb begin
    state_next = state;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          mem_write = 1'b1;
          mem_addr  = head_entry.addr;
          mem_wdata = head_entry.color;
        end
        if (clear_start) state_next = CLEAR_WAIT;
      end
      CLEAR_WAIT: begin
        if (!fifo_empty) begin
          mem_write = 1'b1;
          mem_addr  = head_entry.addr;
          mem_wdata = head_entry.color;
        end else begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        mem_write = 1'b1;
        mem_addr  = fill_addr;
        mem_wdata = clr_color;
        if (mem_grant && (idx == LAST_IDX)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= '0;
      clr_color     <= '0;
      fb_full       <= 1'b0;
      dropped_count <= '0;
    end else begin
      state   <= state_next;
      fb_full <= (count_next == CW'(FIFO_DEPTH)) || (state_next != IDLE);
      if (state == IDLE && clear_start) clr_color <= clear_color;
      if (state != CLEAR)  idx <= '0;
      else if (mem_grant)  idx <= idx + IDX_W'(1);
      if (reject && dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gpu_fb_sink.sv
// +--------------------------------------------------------------------+
// | tb_gpu_fb_sink : randomized bench with queue-based reference model |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_gpu_fb_sink;

  localparam int unsigned W     = 16;
  localparam int unsigned H     = 4;
  localparam int unsigned BASE  = 32'h0000_FFE8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NPIX  = W * H;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  fb_x, fb_y;
  logic [15:0] fb_color, clear_color;
  logic        fb_write, clear_start, mem_grant;
  logic        fb_full, clear_busy, mem_write;
  logic [15:0] mem_addr, mem_wdata, dropped_count;

  always #5 clk = ~clk;

  gpu_fb_sink #(
    .FB_WIDTH   (W),
    .FB_HEIGHT  (H),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .fb_x          (fb_x),
    .fb_y          (fb_y),
    .fb_color      (fb_color),
    .fb_write      (fb_write),
    .fb_full       (fb_full),
    .clear_start   (clear_start),
    .clear_color   (clear_color),
    .clear_busy    (clear_busy),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_write     (mem_write),
    .mem_grant     (mem_grant),
    .dropped_count (dropped_count)
  );

  // Stimulus staged here and applied on the falling edge.
  logic        s_rst, s_write, s_cs, s_grant;
  logic [7:0]  s_x, s_y;
  logic [15:0] s_color, s_cc;

  // Reference model: mode 0 = idle, 1 = clear requested, 2 = filling.
  logic [31:0] m_q[$];
  int          m_mode;
  int unsigned m_idx;
  logic [15:0] m_clr;
  logic        m_full;
  int unsigned m_drops;
  logic        m_after_rst;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, obs, exp, $time);
  endtask

  task automatic idle_inputs(input logic grant);
    s_rst = 0; s_write = 0; s_cs = 0; s_grant = grant;
    s_x = 0; s_y = 0; s_color = 0; s_cc = 0;
  endtask

  task automatic cycle();
    logic        exp_w, pop, acc, inr;
    logic [15:0] exp_a, exp_d;
    @(negedge clk);
    if (m_mode == 2) begin
      exp_w = 1; exp_a = 16'(BASE + m_idx); exp_d = m_clr;
    end else if (m_q.size() > 0) begin
      exp_w = 1; exp_a = m_q[0][31:16]; exp_d = m_q[0][15:0];
    end else begin
      exp_w = 0; exp_a = 16'h0; exp_d = 16'h0;
    end
    check_eq("mem_write", 32'(mem_write), 32'(exp_w));
    if (exp_w || m_after_rst) begin
      check_eq("mem_addr", 32'(mem_addr), 32'(exp_a));
      check_eq("mem_wdata", 32'(mem_wdata), 32'(exp_d));
    end
    check_eq("fb_full", 32'(fb_full), 32'(m_full));
    check_eq("clear_busy", 32'(clear_busy), 32'(m_mode != 0));
    check_eq("dropped_count", 32'(dropped_count), m_drops);
    m_after_rst = 0;

    rst = s_rst; fb_write = s_write; fb_x = s_x; fb_y = s_y; fb_color = s_color;
    clear_start = s_cs; clear_color = s_cc; mem_grant = s_grant;
    @(posedge clk);

    if (s_rst) begin
      m_q.delete(); m_mode = 0; m_idx = 0; m_full = 0; m_drops = 0; m_after_rst = 1;
    end else begin
      pop = exp_w && s_grant;
      inr = (32'(s_x) < W) && (32'(s_y) < H);
      acc = s_write && !m_full && inr;
      if (s_write && !acc && m_drops < 32'hFFFF) m_drops++;
      case (m_mode)
        0: begin
          if (pop) void'(m_q.pop_front());
          if (acc) m_q.push_back({16'(BASE + 32'(s_y) * W + 32'(s_x)), s_color});
          if (s_cs) begin m_mode = 1; m_clr = s_cc; end
        end
        1: begin
          if (m_q.size() == 0) begin m_mode = 2; m_idx = 0; end
          else if (pop) void'(m_q.pop_front());
        end
        default: begin
          if (s_grant) begin
            if (m_idx == NPIX - 1) m_mode = 0;
            else m_idx++;
          end
        end
      endcase
      m_full = (m_q.size() == DEPTH) || (m_mode != 0);
    end
  endtask

  task automatic pixel(input int x, input int y, input logic [15:0] c, input logic grant);
    idle_inputs(grant);
    s_write = 1; s_x = 8'(x); s_y = 8'(y); s_color = c;
    cycle();
  endtask

  task automatic idle_cycles(input int n, input logic grant);
    for (int i = 0; i < n; i++) begin
      idle_inputs(grant);
      cycle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int waited;
    rst = 1; fb_write = 0; fb_x = 0; fb_y = 0; fb_color = 0;
    clear_start = 0; clear_color = 0; mem_grant = 0;
    m_mode = 0; m_idx = 0; m_clr = 0; m_full = 0; m_drops = 0; m_after_rst = 1;
    repeat (2) @(posedge clk);

    // Single pixel with permanent grant: visible one cycle later, then gone.
    idle_cycles(1, 1);
    pixel(3, 2, 16'hABCD, 1);
    idle_cycles(3, 1);

    // Back-pressure: no grant, overfill the FIFO, then drain in order.
    for (int i = 0; i < 6; i++) pixel(i, 1, 16'(16'h0100 + i), 0);
    idle_cycles(8, 1);

    // Out-of-range pixels are dropped; address wrap past 0xFFFF.
    pixel(16, 0, 16'h1111, 1);
    pixel(0, 4, 16'h2222, 1);
    pixel(8, 3, 16'h3333, 1);
    idle_cycles(3, 1);

    // Clear with two pending pixels, alternating grant, extra clear_start mid-fill.
    pixel(1, 0, 16'hAAAA, 0);
    pixel(2, 0, 16'hBBBB, 0);
    idle_inputs(0); s_cs = 1; s_cc = 16'h1234; cycle();
    for (int i = 0; i < 2 * NPIX + 20; i++) begin
      idle_inputs(1'(i % 2 == 0));
      if (i == 30) begin s_cs = 1; s_cc = 16'h5555; end
      if (i == 31) begin s_write = 1; s_x = 8'd5; s_y = 8'd1; end
      cycle();
    end

    // Reset in the middle of a clear, at fill index 5.
    idle_inputs(1); s_cs = 1; s_cc = 16'h0F0F; cycle();
    waited = 0;
    while (!(m_mode == 2 && m_idx == 5) && waited < 200) begin
      idle_inputs(1'(waited % 2 == 0));
      cycle();
      waited++;
    end
    check_eq("reached_fill_index_5", 32'(m_mode == 2 && m_idx == 5), 32'd1);
    idle_inputs(0); s_rst = 1; cycle();
    idle_cycles(2, 1);
    pixel(4, 3, 16'hCAFE, 1);
    idle_cycles(3, 1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(0, 599) == 0);
      s_write = 1'($urandom_range(0, 1));
      s_x     = 8'($urandom_range(0, 19));
      s_y     = 8'($urandom_range(0, 5));
      s_color = 16'($urandom);
      s_cs    = ($urandom_range(0, 59) == 0);
      s_cc    = 16'($urandom);
      s_grant = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
